// File: rtl/apb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter_if
//   Bundles the requester-side handshake and the APB-side command/response
//   signals of apb_rr_arbiter.
//
//   Requester side : req, req_wr, req_addr[i], req_wdata[i]   (to arbiter)
//                    ack (one-hot pulse), ack_rdata, err, busy (from arbiter)
//   APB side       : start, wr, address, wdata                (from arbiter)
//                    rdata                                    (to arbiter)
//
//   modport master : the arbiter's view.
//   modport slave  : the environment's view (requesters + APB target).
// ---------------------------------------------------------------------------
interface apb_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    // requester side
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 req_wr;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 ack;
    logic [DATA_WIDTH-1:0]              ack_rdata;
    logic                               err;
    logic                               busy;

    // APB side
    logic                               start;
    logic                               wr;
    logic [ADDR_WIDTH-1:0]              address;
    logic [DATA_WIDTH-1:0]              wdata;
    logic [DATA_WIDTH-1:0]              rdata;

    modport master (
        input  req, req_wr, req_addr, req_wdata, rdata,
        output ack, ack_rdata, err, busy, start, wr, address, wdata
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, rdata,
        input  ack, ack_rdata, err, busy, start, wr, address, wdata
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
//   Round-robin arbiter that funnels NUM_REQ requesters onto one APB-style
//   command port. One transaction at a time: IDLE -> ACCESS -> CAPTURE -> ACK.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : apb_rr_arbiter_if.master
//              req/req_wr/req_addr/req_wdata in, ack/ack_rdata/err/busy out,
//              start/wr/address/wdata out, rdata in.
//
//   Timing (request seen in IDLE cycle 0):
//     start high cycles 1..WAIT_CYCLE+3, CAPTURE cycle WAIT_CYCLE+4,
//     ack pulse cycle WAIT_CYCLE+5, back in IDLE the cycle after.
//
//   Optional feature: define APB_ARB_RANGE_CHECK_EN to reject addresses
//   outside [BASE_ADDR, BASE_ADDR+MEM_SIZE). A rejected request skips the
//   bus access and is acknowledged with err=1 the cycle after IDLE.
//   Without the macro err is constant 0.
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_SIZE   = 32,
    parameter int          WAIT_CYCLE = 3,
    parameter int          NUM_REQ    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    apb_rr_arbiter_if.master       bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WAIT_CYCLE + 4);
    // ACCESS lasts WAIT_CYCLE+3 cycles: counter runs 0 .. WAIT_CYCLE+2
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLE + 2);
    localparam logic [IDX_W-1:0] GNT_RST  = IDX_W'(NUM_REQ - 1);

    // elaboration-time parameter sanity
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("apb_rr_arbiter: NUM_REQ must be 2..8");
    end
    if (MEM_SIZE < 1 ||
        (64'(BASE_ADDR) + 64'(MEM_SIZE)) > (64'd1 << ADDR_WIDTH)) begin : g_bad_range
        $error("apb_rr_arbiter: target window does not fit the address space");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]       winner_q, winner_d;
    logic                   lat_wr_q, lat_wr_d;
    logic [ADDR_WIDTH-1:0]  lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0]  lat_wdata_q, lat_wdata_d;

    logic                   start_q, start_d;
    logic                   wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]  address_q, address_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  ack_rdata_q, ack_rdata_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic                   gnt_found;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       cand;
    logic                   range_err;

    // ---------------------------------------------------------------------
    // Round-robin pick: scan last_gnt+1, last_gnt+2, ... modulo NUM_REQ and
    // take the first requester that is high.
    // ---------------------------------------------------------------------
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_gnt_q;
        cand      = last_gnt_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_gnt_q) + i) % NUM_REQ);
            if (!gnt_found && bus.req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

`ifdef APB_ARB_RANGE_CHECK_EN
    // one extra bit so BASE_ADDR+MEM_SIZE cannot wrap
    localparam logic [ADDR_WIDTH:0] RANGE_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] RANGE_HI = RANGE_LO + (ADDR_WIDTH+1)'(MEM_SIZE);
    logic [ADDR_WIDTH:0] gnt_addr_x;
    assign gnt_addr_x = {1'b0, bus.req_addr[gnt_idx]};
    assign range_err  = (gnt_addr_x < RANGE_LO) || (gnt_addr_x >= RANGE_HI);
`else
    assign range_err  = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = range_err ? ACK : ACCESS;
            ACCESS:  if (cnt_q == CNT_LAST) state_d = CAPTURE;
            CAPTURE: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs and datapath. Every output is a flop loaded from the
    // value it must carry in the *next* state, so outputs line up with the
    // state register without any combinational path to the ports.
    // ---------------------------------------------------------------------
    always_comb begin
        winner_d    = winner_q;
        lat_wr_d    = lat_wr_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        last_gnt_d  = last_gnt_q;
        ack_rdata_d = ack_rdata_q;

        // requests are only looked at in IDLE
        if (state_q == IDLE && gnt_found) begin
            winner_d    = gnt_idx;
            lat_wr_d    = bus.req_wr[gnt_idx];
            lat_addr_d  = bus.req_addr[gnt_idx];
            lat_wdata_d = bus.req_wdata[gnt_idx];
        end

        cnt_d = (state_q == ACCESS && state_d == ACCESS) ? cnt_q + 1'b1 : '0;

        if (state_q == CAPTURE)
            ack_rdata_d = lat_wr_q ? '0 : bus.rdata;
        else if (state_q == IDLE && state_d == ACK)
            ack_rdata_d = '0;

        // fairness pointer moves only once the transaction completes
        if (state_q == ACK)
            last_gnt_d = winner_q;

        start_d   = (state_d == ACCESS);
        wr_d      = (state_d == ACCESS) && lat_wr_d;
        address_d = (state_d == ACCESS) ? lat_addr_d  : address_q;
        wdata_d   = (state_d == ACCESS) ? lat_wdata_d : wdata_q;

        ack_d = '0;
        if (state_d == ACK)
            ack_d[winner_d] = 1'b1;

        // only the IDLE->ACK shortcut is a rejected access
        err_d  = (state_q == IDLE) && (state_d == ACK);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            last_gnt_q  <= GNT_RST;
            winner_q    <= '0;
            lat_wr_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            start_q     <= 1'b0;
            wr_q        <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            ack_q       <= '0;
            ack_rdata_q <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_gnt_q  <= last_gnt_d;
            winner_q    <= winner_d;
            lat_wr_q    <= lat_wr_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            start_q     <= start_d;
            wr_q        <= wr_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            ack_rdata_q <= ack_rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.start     = start_q;
    assign bus.wr        = wr_q;
    assign bus.address   = address_q;
    assign bus.wdata     = wdata_q;
    assign bus.ack       = ack_q;
    assign bus.ack_rdata = ack_rdata_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_rr_arbiter
//   Scoreboard bench for apb_rr_arbiter. Each issued request pushes its
//   expected completion (grantee, cycle, data, err, bus activity); the
//   monitor pops on every ack and compares. A small word memory plays the
//   APB target; a shadow copy gives expected read data.
//   Build with +define+APB_ARB_RANGE_CHECK_EN to cover the range check.
// ---------------------------------------------------------------------------
module tb_apb_rr_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MEM_SIZE   = 32;
    localparam int WAIT_CYCLE = 3;
    localparam int LAT        = WAIT_CYCLE + 5;   // IDLE sample -> ack
    localparam int PERIOD     = WAIT_CYCLE + 6;   // ack to ack, back to back
    localparam int NSTART     = WAIT_CYCLE + 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    apb_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
                        .DATA_WIDTH(DATA_WIDTH)) bus ();

    apb_rr_arbiter #(
        .BASE_ADDR(32'h0000_0000), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .MEM_SIZE(MEM_SIZE), .WAIT_CYCLE(WAIT_CYCLE), .NUM_REQ(NUM_REQ)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // APB target: word memory, write while start&wr, combinational read
    logic [31:0] mem [MEM_SIZE] = '{default: '0};
    always @(posedge clk) if (bus.start && bus.wr) mem[bus.address[4:0]] <= bus.wdata;
    assign bus.rdata = mem[bus.address[4:0]];

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          nstart;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [MEM_SIZE] = '{default: '0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input exp_t e);
        bus.req_wr[e.idx]    = e.wr;
        bus.req_addr[e.idx]  = e.addr;
        bus.req_wdata[e.idx] = e.wdata;
        bus.req[e.idx]       = 1'b1;
    endtask

    // Queue one transaction. A requester with an entry already pending keeps
    // its req high and gets the new command loaded when the previous acks.
    task automatic issue(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ecyc);
        exp_t e;
        logic held;
        held = 1'b0;
        foreach (sb[k]) if (sb[k].idx == idx) held = 1'b1;
        e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata;
        e.err = 1'b0; e.nstart = NSTART; e.cyc = ecyc; e.rdata = '0;
`ifdef APB_ARB_RANGE_CHECK_EN
        if (addr >= MEM_SIZE) begin
            e.err = 1'b1; e.nstart = 0;
        end
`endif
        if (!e.err) begin
            if (wr) shadow[addr[4:0]] = wdata;
            else    e.rdata = shadow[addr[4:0]];
        end
        sb.push_back(e);
        if (!held) drive(e);
    endtask

    // Monitor until the scoreboard drains or the budget runs out.
    task automatic run(input int budget);
        exp_t        e;
        int          n = 0;
        int          scnt = 0;
        int          sfirst = 0;
        logic [31:0] saddr = '0;
        logic [31:0] swdata = '0;
        logic        swr = 1'b0;
        logic        more;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.start) begin
                if (scnt == 0) begin
                    sfirst = cyc; saddr = bus.address; swr = bus.wr; swdata = bus.wdata;
                end
                scnt++;
            end
            if (bus.ack != '0) begin
                e = sb.pop_front();
                chk("ack_onehot", 64'(bus.ack), 64'(1) << e.idx);
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("ack_rdata", 64'(bus.ack_rdata), 64'(e.rdata));
                chk("err", 64'(bus.err), 64'(e.err));
                chk("start_cycles", 64'(scnt), 64'(e.nstart));
                if (e.nstart > 0) begin
                    chk("start_first", 64'(sfirst), 64'(e.cyc - (WAIT_CYCLE + 4)));
                    chk("address", 64'(saddr), 64'(e.addr));
                    chk("wr", 64'(swr), 64'(e.wr));
                    if (e.wr) chk("wdata", 64'(swdata), 64'(e.wdata));
                end
                scnt = 0;
                more = 1'b0;
                foreach (sb[k]) if (!more && sb[k].idx == e.idx) begin
                    drive(sb[k]);
                    more = 1'b1;
                end
                if (!more) bus.req[e.idx] = 1'b0;
            end
        end
        if (sb.size() > 0) begin
            chk("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
            bus.req = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int ecyc;
        bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_start", 64'(bus.start), 64'd0);
        chk("rst_wr", 64'(bus.wr), 64'd0);
        chk("rst_address", 64'(bus.address), 64'd0);
        chk("rst_wdata", 64'(bus.wdata), 64'd0);
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_ack_rdata", 64'(bus.ack_rdata), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;

        // single write, then read back from another requester
        @(negedge clk);
        issue(0, 1'b1, 32'h5, 32'hDEAD_0005, cyc + LAT);
        run(100);
        @(negedge clk);
        issue(2, 1'b0, 32'h5, 32'h0, cyc + LAT);
        run(100);

        // all four from reset: grant 0,1,2,3 one period apart
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        for (int k = 0; k < NUM_REQ; k++)
            issue(k, 1'b1, 32'(8 + k), 32'hA5A5_0000 + 32'(k * 17), c0 + LAT + k * PERIOD);
        run(300);

        // persistent requester re-granted every PERIOD
        @(negedge clk);
        c0 = cyc;
        issue(3, 1'b0, 32'h8,  32'h0, c0 + LAT);
        issue(3, 1'b0, 32'hA,  32'h0, c0 + LAT + PERIOD);
        issue(3, 1'b0, 32'hB,  32'h0, c0 + LAT + 2 * PERIOD);
        run(300);

        // round-robin wrap: after a grant to 2, requester 3 beats requester 0
        @(negedge clk);
        issue(2, 1'b1, 32'hC, 32'h1234_5678, cyc + LAT);
        run(100);
        @(negedge clk);
        c0 = cyc;
        issue(3, 1'b0, 32'hC, 32'h0, c0 + LAT);
        issue(0, 1'b0, 32'h9, 32'h0, c0 + LAT + PERIOD);
        run(200);

        // reset in ACCESS cycle 3: abort, no ack, fresh transaction afterwards
        @(negedge clk);
        c0 = cyc;
        bus.req_wr[1] = 1'b0; bus.req_addr[1] = 32'hB; bus.req[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_start", 64'(bus.start), 64'd1);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_start", 64'(bus.start), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_ack", 64'(bus.ack), 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("ack_in_rst", 64'(bus.ack), 64'd0);
        end
        rst_n = 1'b1;
        issue(1, 1'b0, 32'hB, 32'h0, cyc + LAT);
        run(100);

        // address just past the target window
        @(negedge clk);
        c0 = cyc;
`ifdef APB_ARB_RANGE_CHECK_EN
        ecyc = c0 + 1;
`else
        ecyc = c0 + LAT;
`endif
        issue(3, 1'b0, 32'h20, 32'h0, ecyc);
        run(100);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
